// File: rtl/clap_light_controller.sv
// ---------------------------------------------------------------------------
// clap_light_controller
//
// Turns clap counts from an upstream clap detector into light commands and
// drives a bank of identical PWM-modulated LED outputs.
//
//   count 2 : toggle the light
//   count 3 : step brightness level (0..3, wraps) while the light is on
//   count 4 : light on at full brightness
//   other   : rejected, one-cycle cmd_reject pulse
//
// Each accepted count is decoded in a single cycle, then input is refused for
// HOLDOFF_CYCLES cycles. An auto-off timer switches the light off after
// TIMEOUT_CYCLES cycles without a command.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active high
//   claps_data   in   [CLAPS_WIDTH] consecutive-clap count
//   claps_valid  in   claps_data valid
//   claps_ready  out  controller accepts claps_data (IDLE, not in reset)
//   led_out      out  [LED_WIDTH] PWM LED drive, all bits identical
//   light_on     out  registered light state
//   level        out  [2] registered brightness level
//   cmd_reject   out  one-cycle pulse for a count that is not a command
// ---------------------------------------------------------------------------
module clap_light_controller #(
   parameter int unsigned CLAPS_WIDTH    = 16,
   parameter int unsigned LED_WIDTH      = 8,
   parameter int unsigned PWM_WIDTH      = 8,
   parameter int unsigned HOLDOFF_CYCLES = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [CLAPS_WIDTH-1:0] claps_data,
   input  logic                   claps_valid,
   output logic                   claps_ready,
   output logic [LED_WIDTH-1:0]   led_out,
   output logic                   light_on,
   output logic [1:0]             level,
   output logic                   cmd_reject
);

   localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
   localparam int unsigned TIME_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam logic [TIME_W-1:0] TIME_LAST = TIME_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      HOLDOFF
   } state_t;

   state_t                 state,      state_next;
   logic [CLAPS_WIDTH-1:0] claps_q,    claps_next;
   logic                   light_next;
   logic [1:0]             level_next;
   logic                   reject_next;
   logic [LED_WIDTH-1:0]   led_next;
   logic [HOLD_W-1:0]      hold_cnt,   hold_next;
   logic [TIME_W-1:0]      timer,      timer_next;
   logic [PWM_WIDTH-1:0]   pwm_cnt,    pwm_next;

   // PWM threshold: (level+1) quarters of the PWM period, one bit wider so
   // the product never overflows.
   logic [2:0]             level_plus;
   logic [PWM_WIDTH:0]     pwm_thresh;
   logic                   led_bit;

   assign claps_ready = (state == IDLE) && !reset;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         claps_q    <= '0;
         light_on   <= 1'b0;
         level      <= 2'd3;
         led_out    <= '0;
         cmd_reject <= 1'b0;
         hold_cnt   <= '0;
         timer      <= '0;
         pwm_cnt    <= '0;
      end else begin
         state      <= state_next;
         claps_q    <= claps_next;
         light_on   <= light_next;
         level      <= level_next;
         led_out    <= led_next;
         cmd_reject <= reject_next;
         hold_cnt   <= hold_next;
         timer      <= timer_next;
         pwm_cnt    <= pwm_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next  = state;
      claps_next  = claps_q;
      light_next  = light_on;
      level_next  = level;
      reject_next = 1'b0;
      hold_next   = hold_cnt;
      timer_next  = timer;
      pwm_next    = pwm_cnt + PWM_WIDTH'(1);

      level_plus  = {1'b0, level} + 3'd1;
      pwm_thresh  = (PWM_WIDTH + 1)'(level_plus) << (PWM_WIDTH - 2);
      led_bit     = light_on && ((level == 2'd3) || ({1'b0, pwm_cnt} < pwm_thresh));
      led_next    = {LED_WIDTH{led_bit}};

      unique case (state)
         IDLE: begin
            if (claps_valid) begin
               claps_next = claps_data;
               state_next = DECODE;
            end
         end

         DECODE: begin
            if (claps_q == CLAPS_WIDTH'(2)) begin
               light_next = !light_on;
            end else if (claps_q == CLAPS_WIDTH'(3)) begin
               if (light_on) begin
                  level_next = level + 2'd1;
               end
            end else if (claps_q == CLAPS_WIDTH'(4)) begin
               light_next = 1'b1;
               level_next = 2'd3;
            end else begin
               reject_next = 1'b1;
            end
            hold_next  = '0;
            state_next = HOLDOFF;
         end

         HOLDOFF: begin
            if (hold_cnt == HOLD_LAST) begin
               hold_next  = '0;
               state_next = IDLE;
            end else begin
               hold_next = hold_cnt + HOLD_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Auto-off timer. A decode cycle always restarts it and cannot time
      // out, so a command arriving on the last timer cycle takes precedence.
      if (state == DECODE) begin
         timer_next = '0;
      end else if (!light_on) begin
         timer_next = '0;
      end else if (timer == TIME_LAST) begin
         timer_next = '0;
         light_next = 1'b0;
      end else begin
         timer_next = timer + TIME_W'(1);
      end
   end

endmodule

// File: tb/tb_clap_light_controller.sv
// ---------------------------------------------------------------------------
// tb_clap_light_controller
//
// Scoreboard bench. A reference model advances on every rising edge using
// the command rules directly (busy-cycle countdown, integer timer, modular
// PWM phase) and queues the outputs expected after that edge; a monitor on
// the falling edge pops each entry and compares it with the DUT outputs.
// Stimulus: directed command sequences followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_clap_light_controller;

   localparam int CW = 16;
   localparam int LW = 8;
   localparam int PW = 4;
   localparam int H  = 8;
   localparam int TO = 100;

   logic          clock;
   logic          reset       = 1'b1;
   logic [CW-1:0] claps_data  = '0;
   logic          claps_valid = 1'b0;
   logic          claps_ready;
   logic [LW-1:0] led_out;
   logic          light_on;
   logic [1:0]    level;
   logic          cmd_reject;

   clap_light_controller #(
      .CLAPS_WIDTH    (CW),
      .LED_WIDTH      (LW),
      .PWM_WIDTH      (PW),
      .HOLDOFF_CYCLES (H),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .claps_data  (claps_data),
      .claps_valid (claps_valid),
      .claps_ready (claps_ready),
      .led_out     (led_out),
      .light_on    (light_on),
      .level       (level),
      .cmd_reject  (cmd_reject)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   typedef struct {
      int ready;
      int light;
      int lvl;
      int rej;
      int led;
   } exp_t;

   exp_t exp_q[$];

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   int          m_busy  = 0;   // upcoming cycles in which input is refused
   int          m_pend  = 0;   // a count is waiting to be decoded
   int          m_pval  = 0;
   int          m_light = 0;
   int          m_lvl   = 3;
   int          m_timer = 0;
   int          m_pwm   = 0;
   int          m_led   = 0;
   int          m_rej   = 0;
   int          m_xfers = 0;
   int          m_led_new;
   exp_t        m_e;

   always @(posedge clock) begin
      cycle = cycle + 1;
      if (reset) begin
         m_busy  = 0;
         m_pend  = 0;
         m_light = 0;
         m_lvl   = 3;
         m_timer = 0;
         m_pwm   = 0;
         m_led   = 0;
         m_rej   = 0;
      end else begin
         m_led_new = (m_light != 0 &&
                      (m_lvl == 3 || m_pwm < (m_lvl + 1) * (1 << (PW - 2)))) ? 1 : 0;
         m_rej = 0;
         if (m_pend != 0) begin
            if (m_pval == 2)
               m_light = 1 - m_light;
            else if (m_pval == 3) begin
               if (m_light != 0) m_lvl = (m_lvl + 1) % 4;
            end else if (m_pval == 4) begin
               m_light = 1;
               m_lvl   = 3;
            end else
               m_rej = 1;
            m_pend  = 0;
            m_timer = 0;
            m_busy  = m_busy - 1;
         end else begin
            if (m_light == 0)
               m_timer = 0;
            else if (m_timer == TO - 1) begin
               m_light = 0;
               m_timer = 0;
            end else
               m_timer = m_timer + 1;
            if (m_busy > 0)
               m_busy = m_busy - 1;
            else if (claps_valid) begin
               m_pend  = 1;
               m_pval  = int'(claps_data);
               m_busy  = 1 + H;
               m_xfers = m_xfers + 1;
            end
         end
         m_pwm = (m_pwm + 1) % (1 << PW);
         m_led = m_led_new;
      end
      m_e.ready = (m_busy == 0) ? 1 : 0;
      m_e.light = m_light;
      m_e.lvl   = m_lvl;
      m_e.rej   = m_rej;
      m_e.led   = m_led;
      exp_q.push_back(m_e);
   end

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total = total + 1;
      if (act !== req) begin
         bad = bad + 1;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cycle, act, req);
      end
   endtask

   exp_t mon_e;
   logic [LW-1:0] led_req;

   always @(negedge clock) begin
      if (exp_q.size() == 0) begin
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL scoreboard_empty cycle=%0d actual=0 required=1", cycle);
      end else begin
         mon_e   = exp_q.pop_front();
         led_req = (mon_e.led != 0) ? '1 : '0;
         chk("claps_ready", 32'(claps_ready), 32'((mon_e.ready != 0) && !reset));
         chk("light_on",    32'(light_on),    32'(mon_e.light));
         chk("level",       32'(level),       32'(mon_e.lvl));
         chk("cmd_reject",  32'(cmd_reject),  32'(mon_e.rej));
         chk("led_out",     32'(led_out),     32'(led_req));
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         claps_data = CW'($urandom);
      end
   endtask

   task automatic send(input int v);
      int start;
      bit done;
      start       = m_xfers;
      done        = 1'b0;
      claps_valid = 1'b1;
      claps_data  = CW'(v);
      for (int i = 0; i < 40 && !done; i++) begin
         step();
         if (m_xfers != start) done = 1'b1;
      end
      claps_valid = 1'b0;
      claps_data  = CW'($urandom);
      total = total + 1;
      if (!done) begin
         bad = bad + 1;
         $display("FAIL transfer_timeout cycle=%0d actual=0 required=1", cycle);
      end
   endtask

   task automatic pulse_reset(input int n);
      reset = 1'b1;
      idle(n);
      reset = 1'b0;
   endtask

   initial begin
      int gap;
      int d;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      idle(2);

      // toggle on, full brightness, refusal window
      send(2);
      idle(12);

      // step brightness through 0,1,2,3; dwell at level 0 for two PWM periods
      send(3);
      idle(34);
      for (int i = 0; i < 3; i++) begin
         send(3);
         idle(20);
      end

      // light off: step ignored silently, unknown count rejected
      send(2);
      idle(10);
      send(3);
      idle(10);
      send(7);
      idle(10);
      send(0);
      idle(10);
      send(16'h0102);
      idle(10);

      // auto-off after a full timeout, then a command on timer 97
      send(4);
      idle(110);
      send(4);
      idle(98);
      send(2);
      idle(120);

      // held valid: one transfer per refusal window
      claps_valid = 1'b1;
      claps_data  = CW'(2);
      repeat (60) step();
      claps_valid = 1'b0;
      idle(12);

      // reset in the middle of the refusal window
      send(4);
      idle(3);
      pulse_reset(1);
      idle(20);

      // randomized traffic
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            pulse_reset($urandom_range(1, 3));
         end else begin
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 130) : $urandom_range(0, 12);
            idle(gap);
            if ($urandom_range(0, 4) == 0)
               d = int'(16'($urandom));
            else if ($urandom_range(0, 3) == 0)
               d = $urandom_range(0, 7);
            else
               d = $urandom_range(2, 4);
            send(d);
         end
      end

      idle(15);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/clap_light_controller.md
CLAP_LIGHT_CONTROLLER -- requirements
Module: clap_light_controller

Interface
REQ-001 SHALL provide parameter CLAPS_WIDTH, default 16, width of the clap-count input.
REQ-002 SHALL provide parameter LED_WIDTH, default 8, number of LED outputs driven in parallel.
REQ-003 SHALL provide parameter PWM_WIDTH, default 8, width of the free-running PWM counter (>=2).
REQ-004 SHALL provide parameter HOLDOFF_CYCLES, default 1000, number of cycles input is refused after a command (>=1).
REQ-005 SHALL provide parameter TIMEOUT_CYCLES, default 50000000, number of on-cycles before auto-off (>=2).
REQ-006 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port claps_data, input, CLAPS_WIDTH, consecutive-clap count from the clap detector.
REQ-009 SHALL have port claps_valid, input, 1, claps_data valid.
REQ-010 SHALL have port claps_ready, output, 1, controller accepts claps_data.
REQ-011 SHALL have port led_out, output, LED_WIDTH, PWM-modulated LED drive, all bits identical.
REQ-012 SHALL have port light_on, output, 1, registered logical light state.
REQ-013 SHALL have port level, output, 2, registered brightness level 0..3.
REQ-014 SHALL have port cmd_reject, output, 1, one-cycle pulse when an accepted count is not a command.

Function
REQ-015 SHALL implement states IDLE, DECODE, HOLDOFF; claps_ready = 1 only in IDLE with reset low, derived from the state register.
REQ-016 SHALL transfer on a rising edge where claps_valid && claps_ready: register claps_data, go IDLE -> DECODE.
REQ-017 SHALL, in DECODE, apply exactly one command at the next edge and go to HOLDOFF; light_on/level change 2 edges after the transfer edge.
REQ-018 SHALL decode count 2: toggle light_on; level unchanged.
REQ-019 SHALL decode count 3: if light_on=1, level <= level+1 modulo 4 (3 wraps to 0); if light_on=0, no change and no reject.
REQ-020 SHALL decode count 4: light_on <= 1, level <= 3.
REQ-021 SHALL treat any other count (0, 1, >=5, full CLAPS_WIDTH compared) as reject: no state change, cmd_reject = 1 for the DECODE->HOLDOFF edge's following cycle only.
REQ-022 SHALL stay in HOLDOFF exactly HOLDOFF_CYCLES cycles (counter cleared on entry, exit to IDLE when count = HOLDOFF_CYCLES-1); claps_valid ignored throughout.
REQ-023 SHALL run an auto-off timer while light_on=1, cleared whenever light_on=0 and on every DECODE cycle (including rejects).
REQ-024 SHALL clear light_on when the timer reaches TIMEOUT_CYCLES-1 in IDLE or HOLDOFF; timeout never fires in DECODE (command wins); level retained.
REQ-025 SHALL run pwm_cnt, PWM_WIDTH bits, incrementing every cycle and wrapping from all-ones to 0.
REQ-026 SHALL drive led_out bits = light_on && (level=3 || pwm_cnt < (level+1)*2^(PWM_WIDTH-2)), registered, one cycle after the inputs.
REQ-027 SHALL never drop or duplicate a transfer; a held claps_valid during HOLDOFF is accepted on the first IDLE cycle.

Reset
REQ-028 SHALL, while reset is high at a rising edge, set state IDLE, light_on 0, level 3, led_out 0, cmd_reject 0, all counters 0; claps_ready 0 while reset is high.
REQ-029 SHALL abandon any in-flight command on reset mid-DECODE or mid-HOLDOFF; no partial update visible.

Verification (PWM_WIDTH=4, HOLDOFF_CYCLES=8, TIMEOUT_CYCLES=100)
REQ-030 SHALL test: reset, send 2 -> light_on=1 two edges later, level=3, led_out all-ones; claps_ready low exactly 9 cycles.
REQ-031 SHALL test: light on, send 3 four times -> level 0,1,2,3; at level 0 led_out high for 4 of every 16 cycles.
REQ-032 SHALL test: light off, send 3 -> no change, no cmd_reject; send 7 -> cmd_reject one pulse, no change.
REQ-033 SHALL test: send 4, idle 100 cycles -> light_on falls at timer 99; resend 2 at timer 97 -> timer restarts, light toggled off by command.
REQ-034 SHALL test: hold claps_valid=1 with 2 continuously -> one transfer per 10 cycles, light toggles each time.
REQ-035 SHALL test: assert reset during HOLDOFF cycle 3 -> all outputs at reset values next edge, claps_ready=1 first cycle after reset falls.
